// File: rtl/amiga_clk_ce_gen_if.sv
// Bus for amiga_clk_ce_gen: PLL lock in, per-channel divider programming,
// clock-enable / divided-clock / reset outputs.
interface amiga_clk_ce_gen_if #(
    parameter int NCH  = 4,
    parameter int DIVW = 8
);
    logic                pll_locked;
    logic [NCH*DIVW-1:0] div;
    logic [NCH*DIVW-1:0] phase;
    logic [NCH-1:0]      en_mask;
    logic [NCH-1:0]      ce_out;
    logic [NCH-1:0]      clk_out;
    logic                sys_reset;
    logic                ready;

    modport master (
        output pll_locked, div, phase, en_mask,
        input  ce_out, clk_out, sys_reset, ready
    );
    modport slave (
        input  pll_locked, div, phase, en_mask,
        output ce_out, clk_out, sys_reset, ready
    );
endinterface

// File: rtl/amiga_clk_ce_gen.sv
// Lock-qualified reset sequencer plus NCH phase-aligned programmable
// clock-enable channels for the 28 MHz Amiga system clock domain.
module amiga_clk_ce_chan #(
    parameter int DIVW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [DIVW-1:0] div,
    input  logic [DIVW-1:0] phase,
    input  logic            en,
    output logic            ce,
    output logic            clk_div
);
    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] div_sh;
    logic [DIVW-1:0] phase_sh;
    logic            wrap;

    assign wrap = (cnt == div_sh);

    // Shadows only move at a period boundary, so cnt never exceeds div_sh
    // and a reprogram cannot produce a runt period.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            div_sh   <= '0;
            phase_sh <= '0;
            ce       <= 1'b0;
            clk_div  <= 1'b0;
        end else begin
            if (!run || wrap) begin
                div_sh   <= div;
                phase_sh <= phase;
            end
            cnt     <= (!run || wrap) ? '0 : cnt + DIVW'(1);
            ce      <= run && en && (cnt == phase_sh);
            clk_div <= run && en && (cnt <= (div_sh >> 1));
        end
    end
endmodule

module amiga_clk_ce_gen #(
    parameter int NCH         = 4,
    parameter int DIVW        = 8,
    parameter int RST_HOLD    = 1024,
    parameter int SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               reset,
    amiga_clk_ce_gen_if.slave bus
);
    localparam int HW = (RST_HOLD > 2) ? $clog2(RST_HOLD - 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((RST_HOLD >= 2) ? RST_HOLD - 2 : 0);

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;

    state_t                      state;
    logic [HW-1:0]               hold_cnt;
    logic [SYNC_STAGES-1:0]      lock_pipe;
    logic                        lock_s;
    logic                        sys_reset_q;
    logic                        ready_q;
    logic                        run;
    logic [NCH-1:0][DIVW-1:0]    div_a;
    logic [NCH-1:0][DIVW-1:0]    phase_a;
    logic [NCH-1:0]              ce_q;
    logic [NCH-1:0]              clk_q;

    always_ff @(posedge clk) begin
        if (reset) lock_pipe <= '0;
        else       lock_pipe <= {lock_pipe[SYNC_STAGES-2:0], bus.pll_locked};
    end
    assign lock_s = lock_pipe[SYNC_STAGES-1];

    // HOLD exits after RST_HOLD-1 cycles so RUN starts RST_HOLD cycles after lock_s.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WAIT_LOCK;
            hold_cnt    <= '0;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: if (lock_s) begin
                    hold_cnt <= '0;
                    if (RST_HOLD == 1) begin
                        state       <= RUN;
                        sys_reset_q <= 1'b0;
                        ready_q     <= 1'b1;
                    end else begin
                        state <= HOLD;
                    end
                end
                HOLD: if (!lock_s) begin
                    state <= WAIT_LOCK;
                end else if (hold_cnt == HOLD_LAST) begin
                    state       <= RUN;
                    sys_reset_q <= 1'b0;
                    ready_q     <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
                RUN: if (!lock_s) begin
                    state       <= WAIT_LOCK;
                    sys_reset_q <= 1'b1;
                    ready_q     <= 1'b0;
                end
                default: begin
                    state       <= WAIT_LOCK;
                    sys_reset_q <= 1'b1;
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    // Qualifying with lock_s silences the channels on the same edge the FSM leaves RUN.
    assign run     = (state == RUN) && lock_s;
    assign div_a   = bus.div;
    assign phase_a = bus.phase;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        amiga_clk_ce_chan #(.DIVW(DIVW)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .run     (run),
            .div     (div_a[i]),
            .phase   (phase_a[i]),
            .en      (bus.en_mask[i]),
            .ce      (ce_q[i]),
            .clk_div (clk_q[i])
        );
    end

    assign bus.ce_out    = ce_q;
    assign bus.clk_out   = clk_q;
    assign bus.sys_reset = sys_reset_q;
    assign bus.ready     = ready_q;
endmodule

// File: tb/tb_amiga_clk_ce_gen.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a negedge
// monitor pops and compares them against the DUT.
module tb_amiga_clk_ce_gen;
    localparam int NCH = 4, DIVW = 8, RST_HOLD = 16, SYNC = 2;
    localparam logic [9:0] RST_V = 10'b01_0000_0000;  // {ready, sys_reset, clk_out, ce_out}

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    amiga_clk_ce_gen_if #(.NCH(NCH), .DIVW(DIVW)) bus ();
    amiga_clk_ce_gen #(.NCH(NCH), .DIVW(DIVW), .RST_HOLD(RST_HOLD), .SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        logic [9:0] v;
        string      name;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         dv[NCH];
    int         ph[NCH];
    int         base[NCH];
    logic [3:0] en;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs in RUN: base is the cycle where the channel's count is 0.
    function automatic logic [9:0] exp_run(int c);
        logic [9:0] v;
        int m, r;
        v = 10'b10_0000_0000;
        for (int ch = 0; ch < NCH; ch++) begin
            m = c - base[ch] - 1;
            if (m >= 0 && en[ch]) begin
                r = m % (dv[ch] + 1);
                if (r == ph[ch])       v[ch]     = 1'b1;
                if (r <= dv[ch] / 2)   v[4 + ch] = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic push_win(int from, int to, bit running, string nm);
        for (int c = from; c <= to; c++)
            q.push_back('{cyc: c, v: (running ? exp_run(c) : RST_V), name: nm});
    endtask

    task automatic set_ch(int ch, int d, int p);
        bus.div[ch*DIVW +: DIVW]   = DIVW'(d);
        bus.phase[ch*DIVW +: DIVW] = DIVW'(p);
        dv[ch] = d;
        ph[ch] = p;
    endtask

    task automatic set_base(int b);
        for (int ch = 0; ch < NCH; ch++) base[ch] = b;
    endtask

    task automatic run_to(int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [9:0] act;
        act = {bus.ready, bus.sys_reset, bus.clk_out, bus.ce_out};
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            vectors++;
            if (e.cyc != cyc || act !== e.v) begin
                miscompares++;
                $display("FAIL %s cyc=%0d (due %0d) got rdy/rst/clk/ce=%b want=%b",
                         e.name, cyc, e.cyc, act, e.v);
            end
        end
    end

    initial begin
        int now, cw, r0, rn;
        reset = 1'b1;
        bus.pll_locked = 1'b0;
        bus.div = '0;
        bus.phase = '0;
        set_ch(0, 3, 0);
        set_ch(1, 3, 2);
        set_ch(2, 0, 0);
        set_ch(3, 3, 5);
        en = 4'hF;
        bus.en_mask = en;

        @(negedge clk);
        push_win(cyc + 1, cyc + 3, 0, "reset_state");
        run_to(cyc + 3);

        // Power-up: lock present from release of reset.
        now = cyc;
        reset = 1'b0;
        bus.pll_locked = 1'b1;
        r0 = now + SYNC + RST_HOLD;
        set_base(r0);
        push_win(now + 1, r0 - 1, 0, "powerup_hold");
        push_win(r0, r0 + 23, 1, "run_grid");
        run_to(r0 + 23);

        // Mask ch1 off then back on; pulses must land on the original grid.
        now = cyc;
        en[1] = 1'b0;
        bus.en_mask = en;
        push_win(now + 1, now + 8, 1, "mask_off");
        run_to(now + 8);
        now = cyc;
        en[1] = 1'b1;
        bus.en_mask = en;
        push_win(now + 1, now + 12, 1, "mask_on");
        run_to(now + 12);

        // ch0 divisor 3->7 one cycle into a period.
        while ((cyc - r0) % 4 != 1) @(negedge clk);
        now = cyc;
        bus.div[0 +: DIVW] = DIVW'(7);
        cw = now + 2;
        push_win(now + 1, cw + 1, 1, "div_old_period");
        dv[0] = 7;
        base[0] = cw + 1;
        push_win(cw + 2, cw + 25, 1, "div_new_period");
        run_to(cw + 25);

        // One-cycle lock glitch in RUN.
        now = cyc;
        bus.pll_locked = 1'b0;
        rn = now + SYNC + 1 + RST_HOLD;
        push_win(now + 1, now + SYNC, 1, "lock_drop_lat");
        set_base(rn);
        push_win(now + SYNC + 1, rn - 1, 0, "lock_drop_hold");
        push_win(rn, rn + 15, 1, "lock_realign");
        @(negedge clk);
        bus.pll_locked = 1'b1;
        run_to(rn + 15);

        // Synchronous reset mid-RUN with lock held.
        now = cyc;
        reset = 1'b1;
        rn = now + 1 + SYNC + RST_HOLD;
        set_base(rn);
        push_win(now + 1, rn - 1, 0, "sreset_hold");
        push_win(rn, rn + 15, 1, "sreset_realign");
        @(negedge clk);
        reset = 1'b0;
        run_to(rn + 15);

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            miscompares += q.size();
            $display("FAIL leftover got %0d unchecked entries want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/amiga_clk_ce_gen.md
# amiga_clk_ce_gen

Parametrised clock-enable and reset sequencer for the Amiga core. It runs on the 28 MHz system clock, after the MMCM and its BUFGs. It replaces the free-running 2-bit 7 MHz divider with NCH independently programmable, phase-aligned clock-enable channels. It also gates the system reset on a synchronised PLL lock, so every channel starts from a common phase whenever lock is (re)acquired.

## Interface
- NCH, 4: number of enable channels.
- DIVW, 8: width of per-channel divisor and phase fields.
- RST_HOLD, 1024: cycles sys_reset stays high after lock is seen (≥1).
- SYNC_STAGES, 2: synchroniser depth for pll_locked (≥2).
- clk  in  1  system clock (28 MHz domain).
- reset  in  1  synchronous, active-high reset.
- pll_locked  in  1  MMCM LOCKED; asynchronous to clk.
- div  in  NCH*DIVW  per channel: divide ratio minus 1 (channel i at [i*DIVW +: DIVW]).
- phase  in  NCH*DIVW  per channel: count value at which the enable fires.
- en_mask  in  NCH  per-channel enable; 0 forces that channel's outputs low.
- ce_out  out  NCH  one-cycle clock-enable pulses.
- clk_out  out  NCH  registered divided square wave (fabric use only, never a clock).
- sys_reset  out  1  lock-qualified system reset, active high.
- ready  out  1  high in RUN state.

## Operation
- Lock synchroniser: SYNC_STAGES flops, reset to 0. Output is lock_s.
- Sequencer FSM, with states WAIT_LOCK, HOLD and RUN.
  - reset: go to WAIT_LOCK and clear the hold counter.
  - WAIT_LOCK: when lock_s=1, go to HOLD with hold counter = 0.
  - HOLD: increment the hold counter. When it reaches RST_HOLD-1, go to RUN. If lock_s=0, go to WAIT_LOCK.
  - RUN: if lock_s=0, go to WAIT_LOCK.
- sys_reset = 1 in every state except RUN. ready = (state==RUN). Both are registered.
- Per-channel counter cnt[i] is DIVW bits wide.
  - It is held at 0 outside RUN, so all channels are phase-aligned on RUN entry.
  - In RUN: cnt = (cnt==div_sh) ? 0 : cnt+1.
- Shadow registers div_sh/phase_sh are loaded from the inputs outside RUN and on the cycle a channel wraps (cnt==div_sh). A mid-period change takes effect at the next period boundary and never produces a runt pulse.
- ce_out[i] is registered from: RUN && en_mask[i] && cnt==phase_sh.
  - If phase_sh > div_sh, the channel never pulses.
  - div=0 gives ce_out continuously high.
- clk_out[i] is registered from: RUN && en_mask[i] && (cnt <= div_sh>>1).
  - For odd div+1 the high phase is one cycle longer.
  - div=0 gives constant high.
- en_mask acts on output gating only; counters keep running, so re-enabling a channel preserves its alignment.

## Timing
- Reset values: ce_out=0, clk_out=0, sys_reset=1, ready=0, all counters 0, synchroniser 0.
- Lock latency: pll_locked rising reaches lock_s after SYNC_STAGES cycles. RUN is entered RST_HOLD cycles after lock_s=1.
- Let R be the first cycle with state=RUN.
  - sys_reset=0 and ready=1 from R.
  - cnt=0 at R.
  - ce_out[i] first high at R+1+phase, then every div+1 cycles.
- Lock loss: lock_s falls SYNC_STAGES cycles after pll_locked. The next cycle has sys_reset=1, ready=0, and all ce_out/clk_out low. Counters are held at 0.
- A lock glitch during HOLD restarts the full RST_HOLD count.
- reset during RUN: outputs return to their reset values on the next edge, regardless of lock.
- Simultaneous wrap and input change: the new div/phase is loaded and applies starting at cnt=0 of the next period.

## Test plan
- Power-up: pll_locked=1 at cycle 0, SYNC_STAGES=2, RST_HOLD=16 → sys_reset falls at cycle 18±1 (checked exactly against the FSM). Before that, ce_out=0.
- 7 MHz enable: ch0 div=3, phase=0 → ce_out[0] pulses at R+1, R+5, R+9… and clk_out[0] is 2 high / 2 low. ch1 div=3, phase=2 → pulses at R+3, R+7… (fixed offset of 2 from ch0).
- Live divisor change: ch0 div 3→7 written mid-period → the current 4-cycle period completes, then the next pulse comes 8 cycles later with no extra pulse.
- Lock drop in RUN: pll_locked low for 1 cycle → sys_reset=1 and ce_out=0 within SYNC_STAGES+1 cycles. When lock returns, a full RST_HOLD wait follows and the channels realign to cnt=0.
- Edge values:
  - div=0 → ce_out constantly high in RUN.
  - phase=5, div=3 → no pulses ever.
  - en_mask toggled 0→1 → pulses resume on the original phase grid.
- Synchronous reset asserted mid-RUN → next edge gives all outputs at reset values, then the full lock/HOLD sequence repeats.
